// File: rtl/pwm_drv.sv
// Sign-magnitude H-bridge PWM driver: signed duty word -> forward/reverse channel
// with period-aligned updates and a dead period on every direction reversal.
`timescale 1ns/1ps
module pwm_drv #(
    parameter int DUTY_W    = 14,
    parameter int DEAD_PRDS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DUTY_W-1:0] duty,
    input  logic                     wrt_duty,
    output logic                     CH_A,
    output logic                     CH_B,
    output logic                     prd_strt,
    output logic                     duty_ack
);
    localparam int CNT_W = DUTY_W - 1;
    localparam int DC_W  = (DEAD_PRDS < 2) ? 1 : $clog2(DEAD_PRDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [DC_W-1:0]  DEAD_INIT = DC_W'(DEAD_PRDS);

    typedef enum logic [1:0] {OFF, RUN_A, RUN_B, DEAD} state_e;
    typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_REV} dir_e;

    function automatic dir_e dir_of(input logic signed [DUTY_W-1:0] v);
        if (v == '0)
            dir_of = DIR_NONE;
        else if (v[DUTY_W-1])
            dir_of = DIR_REV;
        else
            dir_of = DIR_FWD;
    endfunction

    // Magnitude with saturation: the most negative word would need CNT_W+1 bits.
    function automatic logic [CNT_W-1:0] mag_of(input logic signed [DUTY_W-1:0] v);
        logic signed [DUTY_W:0] ext;
        logic signed [DUTY_W:0] neg;
        ext = {v[DUTY_W-1], v};
        neg = -ext;
        if (!v[DUTY_W-1])
            mag_of = v[CNT_W-1:0];
        else if (neg[DUTY_W-1])
            mag_of = CNT_MAX;
        else
            mag_of = neg[CNT_W-1:0];
    endfunction

    function automatic state_e run_state(input dir_e d);
        case (d)
            DIR_FWD: run_state = RUN_A;
            DIR_REV: run_state = RUN_B;
            default: run_state = OFF;
        endcase
    endfunction

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [DUTY_W-1:0] shadow_q, shadow_d;
    logic                     pend_q, pend_d;
    logic [CNT_W-1:0]         mag_q, mag_d;
    state_e                   state_q, state_d;
    logic [DC_W-1:0]          dead_q, dead_d;
    logic                     ch_a_q, ch_a_d;
    logic                     ch_b_q, ch_b_d;
    logic                     bnd;
    logic                     consume;
    dir_e                     tgt_dir;
    logic [CNT_W-1:0]         tgt_mag;

    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        bnd      = (cnt_q == CNT_MAX);
        tgt_dir  = dir_of(shadow_q);
        tgt_mag  = mag_of(shadow_q);
        state_d  = state_q;
        mag_d    = mag_q;
        dead_d   = dead_q;
        consume  = 1'b0;

        if (bnd) begin
            unique case (state_q)
                OFF: begin
                    if (pend_q) begin
                        consume = 1'b1;
                        state_d = run_state(tgt_dir);
                        mag_d   = tgt_mag;
                    end
                end
                RUN_A: begin
                    if (pend_q) begin
                        consume = 1'b1;
                        if (tgt_dir == DIR_REV) begin
                            state_d = DEAD;
                            dead_d  = DEAD_INIT;
                        end else begin
                            state_d = run_state(tgt_dir);
                            mag_d   = tgt_mag;
                        end
                    end
                end
                RUN_B: begin
                    if (pend_q) begin
                        consume = 1'b1;
                        if (tgt_dir == DIR_FWD) begin
                            state_d = DEAD;
                            dead_d  = DEAD_INIT;
                        end else begin
                            state_d = run_state(tgt_dir);
                            mag_d   = tgt_mag;
                        end
                    end
                end
                DEAD: begin
                    // Dead time is fixed; late writes only retarget the exit direction.
                    if (dead_q <= DC_W'(1)) begin
                        consume = pend_q;
                        state_d = run_state(tgt_dir);
                        mag_d   = tgt_mag;
                    end else begin
                        dead_d = dead_q - DC_W'(1);
                    end
                end
            endcase
        end

        // A strobe on the boundary cycle lands in the shadow after it was sampled.
        shadow_d = wrt_duty ? duty : shadow_q;
        pend_d   = wrt_duty | (pend_q & ~consume);

        ch_a_d = (state_d == RUN_A) && (cnt_d < mag_d);
        ch_b_d = (state_d == RUN_B) && (cnt_d < mag_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            mag_q    <= '0;
            state_q  <= OFF;
            dead_q   <= '0;
            ch_a_q   <= 1'b0;
            ch_b_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            mag_q    <= mag_d;
            state_q  <= state_d;
            dead_q   <= dead_d;
            ch_a_q   <= ch_a_d;
            ch_b_q   <= ch_b_d;
        end
    end

    assign CH_A     = ch_a_q;
    assign CH_B     = ch_b_q;
    assign prd_strt = (cnt_q == '0) & rst_n;
    assign duty_ack = bnd & consume;

endmodule

// File: tb/tb_pwm_drv.sv
// Bench for pwm_drv: period-level reference model compared every cycle, plus
// per-period high-time and acknowledge totals pinned to hand-computed values.
`timescale 1ns/1ps
module tb_pwm_drv;
    localparam int PER  = 8192;
    localparam int MX   = 8191;
    localparam int DEADN = 1;
    localparam int M_DEAD = 2;   // model modes: 0 off, +1 forward, -1 reverse, 2 dead
    localparam int NPER = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] duty = '0;
    logic        wrt_duty = 1'b0;
    logic        CH_A, CH_B, prd_strt, duty_ack;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit run2 = 1'b0;

    int perA [NPER];
    int perB [NPER];
    int ack_cnt = 0;

    pwm_drv dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (duty),
        .wrt_duty(wrt_duty),
        .CH_A    (CH_A),
        .CH_B    (CH_B),
        .prd_strt(prd_strt),
        .duty_ack(duty_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int mag_of(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > MX) ? MX : a;
    endfunction

    function automatic int dir_of(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    // Reference model and per-cycle comparison, evaluated on the falling edge.
    int  m_cnt, m_mode, m_mag, m_dead, m_shadow, m_cyc;
    bit  m_pend;
    initial begin
        int nm, nmag, nd, d;
        bit took;
        for (int i = 0; i < NPER; i++) begin perA[i] = 0; perB[i] = 0; end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_cnt = 0; m_mode = 0; m_mag = 0; m_dead = 0; m_shadow = 0;
                m_pend = 1'b0; m_cyc = 0;
                check("rst_outputs", {28'd0, CH_A, CH_B, prd_strt, duty_ack}, 32'd0);
            end else begin
                nm = m_mode; nmag = m_mag; nd = m_dead; took = 1'b0;
                if (m_cnt == MX) begin
                    d = dir_of(m_shadow);
                    if (m_mode == M_DEAD) begin
                        if (m_dead <= 1) begin
                            nm = d; nmag = mag_of(m_shadow); took = m_pend;
                        end else begin
                            nd = m_dead - 1;
                        end
                    end else if (m_pend) begin
                        took = 1'b1;
                        if (m_mode * d < 0) begin
                            nm = M_DEAD; nd = DEADN;
                        end else begin
                            nm = d; nmag = mag_of(m_shadow);
                        end
                    end
                end
                check("CH_A", CH_A, (m_mode == 1 && m_cnt < m_mag) ? 1 : 0);
                check("CH_B", CH_B, (m_mode == -1 && m_cnt < m_mag) ? 1 : 0);
                check("prd_strt", prd_strt, (m_cnt == 0) ? 1 : 0);
                check("duty_ack", duty_ack, took ? 1 : 0);
                if (!run2 && m_cyc < NPER * PER) begin
                    perA[m_cyc / PER] += int'(CH_A);
                    perB[m_cyc / PER] += int'(CH_B);
                    ack_cnt += int'(duty_ack);
                end
                m_mode = nm; m_mag = nmag; m_dead = nd;
                if (took) m_pend = 1'b0;
                if (wrt_duty) begin
                    m_shadow = int'($signed(duty));
                    m_pend = 1'b1;
                end
                m_cnt = (m_cnt + 1) % PER;
                m_cyc++;
            end
        end
    end

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wr(input logic [13:0] v);
        duty = v;
        wrt_duty = 1'b1;
        @(posedge clk); #1;
        cyc++;
        wrt_duty = 1'b0;
        duty = 14'($urandom);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int a [NPER];
        int b [NPER];
        a = '{0, 2048, 512, 512, 0, 1, 0, 0, 0};
        b = '{0, 0, 0, 0, 0, 0, 0, 8191, 0};

        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1; cyc = 0;

        // P0 off: random write overwritten by +2048
        goto($urandom_range(50, 3000));            wr(14'($urandom));
        goto($urandom_range(3100, 8000));          wr(14'h0800);
        // P1 run A 2048: last of two writes wins
        goto(PER + $urandom_range(10, 4000));      wr(14'h0100);
        goto(PER + $urandom_range(4100, 8100));    wr(14'h0200);
        // P2 run A 512: zero written on the boundary cycle is deferred
        goto(2 * PER + MX);                        wr(14'h0000);
        // P3 run A 512, then off without dead time
        // P4 off: mag 1
        goto(4 * PER + $urandom_range(0, 8000));   wr(14'h0001);
        // P5 run A mag 1: reversal to -2048
        goto(5 * PER + $urandom_range(0, 3000));   wr(14'($urandom));
        goto(5 * PER + $urandom_range(3100, 8100)); wr(14'h3800);
        // P6 dead: retarget to -8192
        goto(6 * PER + $urandom_range(0, 8100));   wr(14'h2000);
        // P7 run B 8191: reversal to +8191
        goto(7 * PER + $urandom_range(0, 3000));   wr(14'($urandom));
        goto(7 * PER + $urandom_range(3100, 8100)); wr(14'h1FFF);
        // P8 dead, P9 run A 8191: asynchronous reset mid-period
        goto(9 * PER + 4000);
        check("cha_before_rst", CH_A, 1);
        run2 = 1'b1;
        rst_n = 1'b0;
        #1;
        check("cha_async_rst", CH_A, 0);
        check("chb_async_rst", CH_B, 0);
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1; cyc = 0;
        goto(40);
        @(negedge clk); #1;

        for (int i = 0; i < NPER; i++) begin
            check($sformatf("perA[%0d]", i), perA[i], a[i]);
            check($sformatf("perB[%0d]", i), perB[i], b[i]);
        end
        check("ack_count", ack_cnt, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_drv.md
PWM_DRV -- requirements
Module: pwm_drv

Interface
REQ-001 The block SHALL be parameterised by DUTY_W, default 14, the width of the signed duty word; the PWM period is 2^(DUTY_W-1) = 8192 clocks.
REQ-002 The block SHALL be parameterised by DEAD_PRDS, default 1, the number of full periods with both channels low on a direction reversal.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all flops clock on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port duty, input, DUTY_W bits: two's-complement duty command from the PID controller.
REQ-006 The block SHALL have port wrt_duty, input, 1 bit: one-cycle strobe; duty is valid in that cycle.
REQ-007 The block SHALL have port CH_A, output, 1 bit: registered forward-drive PWM.
REQ-008 The block SHALL have port CH_B, output, 1 bit: registered reverse-drive PWM.
REQ-009 The block SHALL have port prd_strt, output, 1 bit: one-cycle pulse in every cycle where cnt = 0.
REQ-010 The block SHALL have port duty_ack, output, 1 bit: one-cycle pulse in the cycle a pending shadow value becomes active.

Function
REQ-011 The block SHALL contain a free-running 13-bit counter cnt that counts 0 to 8191 and then wraps to 0, with no gaps.
REQ-012 On wrt_duty, the block SHALL capture duty into a shadow register and set a pending flag.
- Multiple writes within one period: the last write wins.
REQ-013 The block SHALL convert the shadow value to direction and magnitude as follows:
- Positive value: direction FWD, mag = duty[12:0].
- Negative value: direction REV, mag = -duty.
- -8192 saturates to mag 8191.
- Zero: direction NONE, mag 0.
REQ-014 Activation SHALL occur only at the period boundary, the cycle where cnt = 8191.
- The new state and mag take effect from the next cnt = 0.
- A wrt_duty in that same boundary cycle is NOT taken; it applies at the following boundary.
REQ-015 The state machine SHALL have the states OFF, RUN_A, RUN_B and DEAD, and SHALL evaluate transitions only at the boundary when pending = 1.
- OFF -> RUN_A for FWD, -> RUN_B for REV, stays in OFF for NONE.
- RUN_A -> RUN_A for FWD (mag updated), -> OFF for NONE, -> DEAD for REV.
- RUN_B mirrors RUN_A: -> RUN_B for REV, -> OFF for NONE, -> DEAD for FWD.
- DEAD: counts DEAD_PRDS boundaries, then enters the direction of the latest shadow value (OFF if NONE); writes received during DEAD update the target without extending DEAD.
REQ-016 In each cycle, the outputs SHALL be driven as follows:
- CH_A = 1 iff state = RUN_A and cnt < mag.
- CH_B = 1 iff state = RUN_B and cnt < mag.
- Both SHALL be 0 in OFF and DEAD.
- CH_A and CH_B SHALL never both be 1.
REQ-017 Both channels SHALL be glitch-free flop outputs (decoded from next-state and next-cnt), and mag SHALL never change mid-period.
REQ-018 duty_ack SHALL pulse in the boundary cycle that consumes pending, including when entering DEAD, and pending SHALL clear in that cycle.
REQ-019 Extreme magnitudes SHALL behave as follows:
- mag = 8191 gives 8191 high cycles per 8192.
- mag = 1 gives exactly one high cycle, at cnt = 0.

Reset
REQ-020 While rst_n = 0, the block SHALL hold cnt = 0, shadow = 0, pending = 0, mag = 0, state = OFF, and CH_A = CH_B = prd_strt = duty_ack = 0.
REQ-021 The first cycle after rst_n deasserts SHALL have cnt = 0 and prd_strt = 1.
REQ-022 If rst_n asserts mid-period or during DEAD, the block SHALL abandon all pending and active values, with both outputs low immediately (asynchronous).

Verification
REQ-023 duty = 0x0800 (+2048), strobed mid-period -> CH_A high for exactly 2048 cycles per period, starting at the next cnt = 0; CH_B = 0; one duty_ack pulse.
REQ-024 duty = 0x3800 (-2048) written while in RUN_A -> one full period (8192 cycles) with both channels low, then CH_B high 2048 cycles per period.
REQ-025 duty = 0x2000 (-8192) -> CH_B high 8191 cycles per period; duty = 0x1FFF -> CH_A high 8191 cycles per period.
REQ-026 Writes of 0x0100 then 0x0200 within one period -> next period uses 512; a write exactly at cnt = 8191 is deferred by one period.
REQ-027 duty = 0x0000 from RUN_A -> OFF at the next boundary, with both channels low and no DEAD period.
REQ-028 rst_n pulsed low at cnt = 4000 during RUN_A -> CH_A falls without waiting for a clock edge; after release, cnt restarts at 0 and state = OFF.
